aes_round_ctrl: RTL and testbench

Sequencer for the AES-128 round-state memory. On `start`, it steps the round index from 0 to NUM_ROUNDS-1. For each round it:
- reads state entry `r` from the round-state memory,
- presents it to the round-function datapath with a valid/ready handshake,
- writes the returned state into entry `r+1`.

It has no data path of its own. It drives only the memory controls (`round_index`, `re`, `we`) and the round-unit handshake. It also reports `busy`, `done` and a sticky timeout `err`.

---
 rtl/aes_round_ctrl_pkg.sv | 15 +
 rtl/aes_round_ctrl_if.sv | 25 ++
 rtl/aes_round_ctrl_ack_timer.sv | 28 ++
 rtl/aes_round_ctrl.sv | 105 ++++++++++
 tb/tb_aes_round_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Imported by the controller, its timer and the round-unit interface.
package aes_ctrl_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int RIDX_W        = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    DONE
  } ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Round-state memory controls plus the round-unit valid/ready handshake.
// The master is the sequencer; the slave is the memory and round unit.
interface aes_round_if;
  import aes_ctrl_pkg::*;

  logic [RIDX_W-1:0] round_index;
  logic              re;
  logic              we;
  logic              rnd_valid;
  logic              rnd_last;
  logic              rnd_ready;

  modport master (
    output round_index, re, we,
    output rnd_valid, rnd_last,
    input  rnd_ready
  );

  modport slave (
    input  round_index, re, we,
    input  rnd_valid, rnd_last,
    output rnd_ready
  );

endinterface

// File: rtl/aes_round_ctrl_ack_timer.sv
// Per-round acknowledge timer: counts RUN cycles without rnd_ready.
// Flags expiry on the last allowed cycle so the FSM can bail out.
module aes_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [W-1:0] LIM = W'(ACK_TIMEOUT - 1);

  logic [W-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tcnt <= '0;
    end else if (en) begin
      tcnt <= tcnt + W'(1);
    end
  end

  assign expire = (tcnt == LIM);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: walks round-state memory entries 0..N-1
// through the round unit and writes each result to the next entry.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS  = AES128_ROUNDS,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  aes_round_if.master rif,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [RIDX_W-1:0] LAST = RIDX_W'(NUM_ROUNDS - 1);

  ctrl_state_e       state;
  logic [RIDX_W-1:0] idx;
  logic              err_q;
  logic              expire;
  logic              in_run;

  assign in_run = (state == RUN);

  aes_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_run),
    .en     (in_run && !rif.rnd_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            err_q <= 1'b0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (rif.rnd_ready) begin
            if (idx == LAST) begin
              state <= DONE;
            end else begin
              idx   <= idx + RIDX_W'(1);
              state <= GAP;
            end
          end else if (expire) begin
            err_q <= 1'b1;
            state <= IDLE;
          end
        end
        GAP: begin
          state <= abort ? IDLE : RUN;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write is gated by rst so a reset mid-round never commits a result.
  always_comb begin
    rif.round_index = '0;
    rif.re          = 1'b0;
    rif.we          = 1'b0;
    rif.rnd_valid   = 1'b0;
    rif.rnd_last    = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    unique case (state)
      RUN: begin
        rif.round_index = idx;
        rif.re          = 1'b1;
        rif.rnd_valid   = 1'b1;
        rif.rnd_last    = (idx == LAST);
        rif.we          = rif.rnd_ready && !abort && !rst;
        busy            = 1'b1;
      end
      GAP:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboarded bench for aes_round_ctrl (N=10 instance plus an N=1 instance).
// Expected write entries are queued at start and popped on every we.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic start1;
  logic zw, rdy;
  logic busy, done, err;
  logic busy1, done1, err1;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  aes_round_if m ();
  aes_round_if m1 ();

  assign m.rnd_ready  = zw ? m.rnd_valid : rdy;
  assign m1.rnd_ready = m1.rnd_valid;

  aes_round_ctrl #(
    .NUM_ROUNDS  (10),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .rif   (m),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  aes_round_ctrl #(
    .NUM_ROUNDS  (1),
    .ACK_TIMEOUT (16)
  ) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .abort (1'b0),
    .rif   (m1),
    .busy  (busy1),
    .done  (done1),
    .err   (err1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (m.we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("we_unexpected", 32'(m.round_index) + 1, 32'hFFFF);
      end else begin
        chk("we_entry", 32'(m.round_index) + 1, 32'(exp_q.pop_front()));
      end
    end
    if (busy && !m.re) chk("gap_valid", 32'(m.rnd_valid), 0);
  end

  task automatic push_block(input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back(i);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("done_seen", 32'(seen), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int d;
    int dc0;
    int wc0;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start1 = 1'b0; zw = 1'b1; rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_re", 32'(m.re), 0);
    chk("rst_valid", 32'(m.rnd_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // zero-wait full block
    push_block(10);
    do_start();
    for (int k = 1; k <= 21; k++) begin
      if (k <= 19 && (k % 2) == 1) begin
        chk("zw_re", 32'(m.re), 1);
        chk("zw_we", 32'(m.we), 1);
        chk("zw_idx", 32'(m.round_index), 32'((k - 1) / 2));
        chk("zw_last", 32'(m.rnd_last), 32'(k == 19));
      end else if (k <= 18) begin
        chk("zw_gap_busy", 32'(busy), 1);
      end else if (k == 20) begin
        chk("zw_done", 32'(done), 1);
      end else begin
        chk("zw_idle_busy", 32'(busy), 0);
        chk("zw_idle_done", 32'(done), 0);
      end
      @(posedge clk); #1;
    end
    chk("zw_q_empty", 32'(exp_q.size()), 0);

    // random ready delay
    zw = 1'b0;
    wc0 = wr_cnt;
    push_block(10);
    do_start();
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 20 && !m.rnd_valid; i++) begin
        @(posedge clk); #1;
      end
      chk("rd_valid", 32'(m.rnd_valid), 1);
      chk("rd_idx", 32'(m.round_index), 32'(r));
      d = $urandom_range(0, 5);
      repeat (d) begin
        @(posedge clk); #1;
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0;
    end
    chk("rd_done", 32'(done), 1);
    chk("rd_err", 32'(err), 0);
    chk("rd_writes", 32'(wr_cnt - wc0), 10);
    chk("rd_q_empty", 32'(exp_q.size()), 0);
    @(posedge clk); #1;

    // timeout
    do_start();
    chk("to_re", 32'(m.re), 1);
    chk("to_idx", 32'(m.round_index), 0);
    repeat (15) begin
      @(posedge clk); #1;
    end
    chk("to_c16_busy", 32'(busy), 1);
    chk("to_c16_err", 32'(err), 0);
    @(posedge clk); #1;
    chk("to_c17_err", 32'(err), 1);
    chk("to_c17_busy", 32'(busy), 0);
    zw = 1'b1;
    push_block(10);
    do_start();
    chk("to_err_clr", 32'(err), 0);
    wait_done(40);
    chk("to_q_empty", 32'(exp_q.size()), 0);

    // abort with ready at idx 4
    dc0 = done_cnt;
    push_block(4);
    do_start();
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("ab_idx", 32'(m.round_index), 4);
    abort = 1'b1;
    #1;
    chk("ab_we", 32'(m.we), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("ab_no_done", 32'(done_cnt - dc0), 0);
    chk("ab_q_empty", 32'(exp_q.size()), 0);

    // start ignored in RUN, reset at idx 6
    push_block(6);
    do_start();
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("st_idx2", 32'(m.round_index), 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("st_idx6", 32'(m.round_index), 6);
    rst = 1'b1;
    #1;
    chk("rs_we", 32'(m.we), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rs_busy", 32'(busy), 0);
    chk("rs_re", 32'(m.re), 0);
    chk("rs_valid", 32'(m.rnd_valid), 0);
    chk("rs_ridx", 32'(m.round_index), 0);
    chk("rs_q_empty", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    push_block(10);
    do_start();
    chk("rs_restart_idx", 32'(m.round_index), 0);
    chk("rs_restart_re", 32'(m.re), 1);
    wait_done(40);
    chk("rs_q_empty2", 32'(exp_q.size()), 0);

    // single-round instance
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("n1_re", 32'(m1.re), 1);
    chk("n1_last", 32'(m1.rnd_last), 1);
    chk("n1_we", 32'(m1.we), 1);
    chk("n1_entry", 32'(m1.round_index) + 1, 1);
    @(posedge clk); #1;
    chk("n1_done", 32'(done1), 1);
    @(posedge clk); #1;
    chk("n1_busy", 32'(busy1), 0);
    chk("n1_done_low", 32'(done1), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
